// File: rtl/core_pkg.sv
// Core-wide widths and types shared by the pipeline registers and the
// architectural register file.
package core_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned CNT_W    = 16;

  localparam logic [DATA_W-1:0] RST_VAL = 8'h00;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // Write-back bundle leaving the EX/WB pipeline register.
  typedef struct packed {
    logic     we;
    reg_idx_t idx;
    data_t    data;
  } wb_bundle_t;

endpackage

// File: rtl/wb_reg_file_if.sv
// Write-back and read-port bundle between the pipeline and the register file.
interface wb_reg_file_if;
  import core_pkg::*;

  logic     RegWrite_EX_WB;
  reg_idx_t Write_reg_EX_WB;
  data_t    ALU_result_EX_WB;
  reg_idx_t Read_reg1;
  reg_idx_t Read_reg2;
  reg_idx_t Dbg_reg;
  data_t    Read_data1;
  data_t    Read_data2;
  data_t    Dbg_data;
  cnt_t     Write_count;

  modport master (
    output RegWrite_EX_WB, Write_reg_EX_WB, ALU_result_EX_WB,
    output Read_reg1, Read_reg2, Dbg_reg,
    input  Read_data1, Read_data2, Dbg_data, Write_count
  );

  modport slave (
    input  RegWrite_EX_WB, Write_reg_EX_WB, ALU_result_EX_WB,
    input  Read_reg1, Read_reg2, Dbg_reg,
    output Read_data1, Read_data2, Dbg_data, Write_count
  );

endinterface

// File: rtl/wb_reg_file_rf_read_port.sv
// Combinational register read port: index mux with optional write-to-read bypass.
module rf_read_port
  import core_pkg::*;
(
  input  logic                           bypass_en,
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  wb_bundle_t                     wb,
  input  reg_idx_t                       rd_idx,
  output data_t                          rd_data
);

  always_comb begin
    rd_data = regs[rd_idx];
    if (bypass_en && wb.we && (wb.idx == rd_idx)) begin
      rd_data = wb.data;
    end
  end

endmodule

// File: rtl/wb_reg_file.sv
// Architectural register file: one write-back port, two bypassed operand
// read ports, one committed-state debug port and a saturating write counter.
module wb_reg_file
  import core_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  wb_reg_file_if.slave  rf
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  cnt_t                            write_cnt;
  wb_bundle_t                      wb;

  assign wb = '{we: rf.RegWrite_EX_WB, idx: rf.Write_reg_EX_WB, data: rf.ALU_result_EX_WB};

  // Commit and count; asynchronous clear always wins over a pending write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= RST_VAL;
      end
      write_cnt <= '0;
    end else if (wb.we) begin
      regs[wb.idx] <= wb.data;
      if (write_cnt != '1) begin
        write_cnt <= write_cnt + CNT_W'(1);
      end
    end
  end

  assign rf.Write_count = write_cnt;

  rf_read_port u_rd1 (
    .bypass_en (BYPASS_EN),
    .regs      (regs),
    .wb        (wb),
    .rd_idx    (rf.Read_reg1),
    .rd_data   (rf.Read_data1)
  );

  rf_read_port u_rd2 (
    .bypass_en (BYPASS_EN),
    .regs      (regs),
    .wb        (wb),
    .rd_idx    (rf.Read_reg2),
    .rd_data   (rf.Read_data2)
  );

  // Debug view reflects committed state only.
  rf_read_port u_dbg (
    .bypass_en (1'b0),
    .regs      (regs),
    .wb        (wb),
    .rd_idx    (rf.Dbg_reg),
    .rd_data   (rf.Dbg_data)
  );

endmodule
